lbp_core: RTL

Synthesizable local-binary-pattern engine for the 128x128 grayscale image subsystem. It acts as the initiator on the gray-pixel read interface and the LBP-result write interface. Those interfaces are served by the host memory model and the `lbp_mem` result store. The core fetches 3x3 neighbourhoods, computes one 8-bit LBP code per interior pixel, writes it out, then raises `finish`.

---
 rtl/lbp_pkg.sv | 13 +
 rtl/lbp_window.sv | 44 ++++
 rtl/lbp_core.sv | 97 +++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared state encoding, default image size and LBP bit-weight positions
package lbp_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_e;
    localparam int IMG_W_DEF = 128;
    localparam int BIT_TL = 0;
    localparam int BIT_T  = 1;
    localparam int BIT_TR = 2;
    localparam int BIT_L  = 3;
    localparam int BIT_R  = 4;
    localparam int BIT_BL = 5;
    localparam int BIT_B  = 6;
    localparam int BIT_BR = 7;
endpackage

// File: rtl/lbp_window.sv
// lbp_window: 3x3 pixel window with left-shifting columns and combinational LBP code
module lbp_window
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [1:0]    row_i,
    input  logic [DW-1:0] data_i,
    output logic [7:0]    code_o
);
    logic [DW-1:0] w_q [3][3];

    // Row 0 of a new column shifts every row left; each read lands in the right column of its row
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q <= '{default: '0};
        end else if (load_i) begin
            for (int i = 0; i < 3; i++) begin
                if (shift_i) begin
                    w_q[i][0] <= w_q[i][1];
                    w_q[i][1] <= w_q[i][2];
                end
                if (row_i == 2'(i)) w_q[i][2] <= data_i;
            end
        end
    end

    // Each neighbour contributes one bit when it is not darker than the center
    always_comb begin
        code_o         = '0;
        code_o[BIT_TL] = w_q[0][0] >= w_q[1][1];
        code_o[BIT_T]  = w_q[0][1] >= w_q[1][1];
        code_o[BIT_TR] = w_q[0][2] >= w_q[1][1];
        code_o[BIT_L]  = w_q[1][0] >= w_q[1][1];
        code_o[BIT_R]  = w_q[1][2] >= w_q[1][1];
        code_o[BIT_BL] = w_q[2][0] >= w_q[1][1];
        code_o[BIT_B]  = w_q[2][1] >= w_q[1][1];
        code_o[BIT_BR] = w_q[2][2] >= w_q[1][1];
    end
endmodule

// File: rtl/lbp_core.sv
// lbp_core: raster-order LBP engine; LBP_COLUMN_REUSE_EN refetches only the new column within a row
module lbp_core
    import lbp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [DW-1:0] lbp_data,
    output logic          finish
);
    localparam logic [AW-1:0] LAST  = AW'(IMG_W - 2);
    localparam logic [AW-1:0] WIDTH = AW'(IMG_W);
`ifdef LBP_COLUMN_REUSE_EN
    localparam logic [1:0] NEXT_FC = 2'd2;
`else
    localparam logic [1:0] NEXT_FC = 2'd0;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] r_q, r_d, c_q, c_d;
    logic [1:0]    fc_q, fc_d, fr_q, fr_d;
    logic          load;
    logic [7:0]    code;

    assign load      = (state_q == FETCH) && gray_ready;
    assign gray_req  = load;
    assign gray_addr = (r_q + AW'(fr_q) - AW'(1)) * WIDTH + c_q + AW'(fc_q) - AW'(1);
    assign lbp_valid = state_q == WRITE;
    assign lbp_addr  = lbp_valid ? r_q * WIDTH + c_q : '0;
    assign lbp_data  = lbp_valid ? DW'(code) : '0;
    assign finish    = state_q == DONE;

    lbp_window #(.DW(DW)) u_window (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (load && fr_q == 2'd0),
        .row_i   (fr_q),
        .data_i  (gray_data),
        .code_o  (code)
    );

    // State and counter registers; reset returns to the first center
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= AW'(1);
            c_q     <= AW'(1);
            fc_q    <= '0;
            fr_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            fc_q    <= fc_d;
            fr_q    <= fr_d;
        end
    end

    // Fetch walks rows within a column, columns left to right; a stall freezes everything
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        fc_d    = fc_q;
        fr_d    = fr_q;
        case (state_q)
            IDLE: if (gray_ready) begin
                state_d = FETCH;
                fc_d    = '0;
                fr_d    = '0;
            end
            FETCH: if (gray_ready) begin
                fr_d = fr_q == 2'd2 ? 2'd0 : fr_q + 2'd1;
                fc_d = fr_q == 2'd2 && fc_q != 2'd2 ? fc_q + 2'd1 : fc_q;
                state_d = fr_q == 2'd2 && fc_q == 2'd2 ? WRITE : FETCH;
            end
            WRITE: begin
                fr_d    = '0;
                fc_d    = c_q == LAST ? 2'd0 : NEXT_FC;
                c_d     = c_q == LAST ? AW'(1) : c_q + AW'(1);
                r_d     = c_q == LAST && r_q != LAST ? r_q + AW'(1) : r_q;
                state_d = c_q == LAST && r_q == LAST ? DONE : FETCH;
            end
            default: state_d = DONE;
        endcase
    end
endmodule
